// File: rtl/dq_line_pkg.sv
// Shared state encoding, direction constants and sizing helper for the dq line endpoint.
package dq_line_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_TURN    = 3'd1;
    localparam state_t S_WRITE   = 3'd2;
    localparam state_t S_RD_WAIT = 3'd3;
    localparam state_t S_READ    = 3'd4;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dq_line_if.sv
// Command / write-data / read-data handshake between a burst source and the line endpoint.
interface dq_line_if #(parameter int DW = 8);
    logic          cmd_valid;
    logic          cmd_write;
    logic          cmd_ready;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          oe;

    modport master (
        output cmd_valid, cmd_write, wr_data,
        input  cmd_ready, wr_ready, rd_data, rd_valid, oe
    );

    modport slave (
        input  cmd_valid, cmd_write, wr_data,
        output cmd_ready, wr_ready, rd_data, rd_valid, oe
    );
endinterface

// File: rtl/dq_io_cell.sv
// Tri-state dq driver plus the registered read-capture stage.
module dq_io_cell #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          oe,
    input  logic [DW-1:0] wr_data,
    input  logic          sample,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    inout  wire  [DW-1:0] dq
);

    assign dq = oe ? wr_data : {DW{1'bz}};

    // Z/X on the line is captured as-is so the bench can see a floating bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= sample;
            if (sample) rd_data <= dq;
        end
    end

endmodule

// File: rtl/dq_line_endpoint.sv
// Controller end of a delayed bidirectional data line: direction tracking,
// turnaround insertion, write-burst drive and read-latency-timed capture.
module dq_line_endpoint
    import dq_line_pkg::*;
#(
    parameter int DW     = 8,
    parameter int BURST  = 4,
    parameter int RD_LAT = 4,
    parameter int TURN   = 2
) (
    input  logic          clk,
    input  logic          reset,
    dq_line_if.slave      bus,
    inout  wire  [DW-1:0] dq
);

    localparam int CW = $clog2(max3(BURST, RD_LAT, TURN) + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);
    localparam logic [CW-1:0] RDLAT_LAST = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] TURN_LAST  = CW'((TURN > 0) ? TURN - 1 : 0);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          last_dir;
    logic          oe_q;
    logic          wr_rdy_q;
    logic          accept;

    assign bus.cmd_ready = (state == S_IDLE) && reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (TURN > 0 && bus.cmd_write != last_dir) nxt = S_TURN;
                else nxt = bus.cmd_write ? S_WRITE : S_RD_WAIT;
            end
            S_TURN:    if (cnt == TURN_LAST)
                           nxt = (last_dir == DIR_WRITE) ? S_WRITE : S_RD_WAIT;
            S_WRITE:   if (cnt == BURST_LAST) nxt = S_IDLE;
            S_RD_WAIT: if (cnt == RDLAT_LAST) nxt = S_READ;
            S_READ:    if (cnt == BURST_LAST) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Counter restarts on every state change; IDLE holds it at zero so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last_dir <= DIR_READ;
            oe_q     <= 1'b0;
            wr_rdy_q <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= (nxt != state || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (accept) last_dir <= bus.cmd_write;
            oe_q     <= (nxt == S_WRITE);
            wr_rdy_q <= (nxt == S_WRITE);
        end
    end

    assign bus.oe       = oe_q;
    assign bus.wr_ready = wr_rdy_q;

    dq_io_cell #(.DW(DW)) u_io (
        .clk      (clk),
        .reset    (reset),
        .oe       (oe_q),
        .wr_data  (bus.wr_data),
        .sample   (state == S_READ),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .dq       (dq)
    );

endmodule

// File: tb/tb_dq_line_endpoint.sv
// Scoreboard bench: TURN=2 and TURN=0 endpoints driven in turn with random bursts.
module tb_dq_line_endpoint;
    localparam int DW = 8, BURST = 4, RD_LAT = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0, cv = 1'b0, cw = 1'b0;
    logic [DW-1:0] wd = '0, drv_val = '0;
    logic          drv_en = 1'b0;
    wire  [DW-1:0] dq0, dq1;

    dq_line_if #(.DW(DW)) bus0();
    dq_line_if #(.DW(DW)) bus1();

    assign bus0.cmd_valid = cv & ~sel;
    assign bus0.cmd_write = cw;
    assign bus0.wr_data   = wd;
    assign bus1.cmd_valid = cv & sel;
    assign bus1.cmd_write = cw;
    assign bus1.wr_data   = wd;
    assign dq0 = (drv_en && !sel) ? drv_val : {DW{1'bz}};
    assign dq1 = (drv_en &&  sel) ? drv_val : {DW{1'bz}};

    dq_line_endpoint #(.DW(DW), .BURST(BURST), .RD_LAT(RD_LAT), .TURN(2)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0), .dq(dq0));
    dq_line_endpoint #(.DW(DW), .BURST(BURST), .RD_LAT(RD_LAT), .TURN(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1), .dq(dq1));

    wire          cr_s = sel ? bus1.cmd_ready : bus0.cmd_ready;
    wire          wr_s = sel ? bus1.wr_ready  : bus0.wr_ready;
    wire          rv_s = sel ? bus1.rd_valid  : bus0.rd_valid;
    wire          oe_s = sel ? bus1.oe        : bus0.oe;
    wire [DW-1:0] rd_s = sel ? bus1.rd_data   : bus0.rd_data;
    wire [DW-1:0] dq_s = sel ? dq1 : dq0;
    wire          quiet_other = sel ? (bus0.wr_ready | bus0.rd_valid | bus0.oe)
                                    : (bus1.wr_ready | bus1.rd_valid | bus1.oe);

    typedef struct {
        bit            rd;
        int            cyc;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] wmap[int];
    logic [DW-1:0] rmap[int];
    int  cyc = 0, free_c = 0, turn_m = 2, last_first = 0;
    int  checks = 0, failures = 0;
    bit  last_dir = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, sel %0d)", nm, act, exp, cyc, sel);
        end
    endtask

    // Cycle counter plus the write source and the far end of the line.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        wd      = wmap.exists(cyc) ? wmap[cyc] : DW'($urandom);
        drv_en  = rmap.exists(cyc);
        drv_val = drv_en ? rmap[cyc] : '0;
    end

    // Monitor: compares every presented beat against the head of the expectation queue.
    initial forever begin
        beat_t e;
        @(negedge clk);
        check("idle_dut_quiet", quiet_other, 0);
        if (rst_n) begin
            check("cmd_ready", cr_s, cyc >= free_c);
            check("oe_vs_wr_ready", oe_s, wr_s);
            if (wr_s || rv_s) begin
                if (q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = q.pop_front();
                    check("beat_kind", rv_s, e.rd);
                    check("beat_cycle", cyc, e.cyc);
                    check("beat_data", rv_s ? rd_s : dq_s, e.data);
                end
            end
        end
    end

    // Reference: accept at max(request, free); turnaround only on a direction change.
    task automatic issue(input bit w, input int gap);
        int r, acc, t;
        logic [DW-1:0] d;
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        cv = 1'b1; cw = w; r = cyc; acc = -1;
        for (int k = 0; k < 100 && acc < 0; k++) begin
            @(negedge clk); #1;
            if (cr_s) acc = cyc;
        end
        if (acc < 0) begin
            check("accept_timeout", 0, 1);
            cv = 1'b0;
            return;
        end
        check("accept_cycle", acc, (r > free_c) ? r : free_c);
        t = (turn_m > 0 && w != last_dir) ? turn_m : 0;
        last_dir = w;
        last_first = acc + t + (w ? 1 : RD_LAT + 1);
        for (int b = 0; b < BURST; b++) begin
            d = DW'($urandom);
            if (w) begin
                wmap[last_first + b] = d;
                q.push_back('{1'b0, last_first + b, d});
            end else begin
                rmap[last_first + b] = d;
                q.push_back('{1'b1, last_first + b + 1, d});
            end
        end
        free_c = acc + t + (w ? BURST : RD_LAT + BURST) + 1;
        @(posedge clk); #1;
        cv = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (q.size() != 0 || cyc < free_c); k++) @(posedge clk);
        check("drain_empty", q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_oe"}, oe_s, 0);
        check({tag, "_wr_ready"}, wr_s, 0);
        check({tag, "_rd_valid"}, rv_s, 0);
        check({tag, "_rd_data"}, rd_s, 0);
        check({tag, "_cmd_ready"}, cr_s, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within its time budget");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        #2; rst_n = 1'b1; last_dir = 1'b0; free_c = cyc;

        // TURN=2 endpoint: write, write, read, then random traffic.
        issue(1'b1, 0);
        issue(1'b1, 0);
        issue(1'b0, 0);
        repeat (30) issue(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        drain();

        // Reset during the second beat of a write.
        issue(1'b0, 0);
        drain();
        issue(1'b1, 0);
        while (cyc < last_first + 1) begin @(posedge clk); #2; end
        #1;
        rst_n = 1'b0;
        q.delete(); wmap.delete(); rmap.delete();
        #1;
        reset_checks("midburst_rst");
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1; last_dir = 1'b0; free_c = cyc;
        issue(1'b1, 0);
        issue(1'b0, 1);
        drain();

        // TURN=0 endpoint: commands held across busy READ cycles.
        #1; sel = 1'b1; turn_m = 0; last_dir = 1'b0; free_c = cyc;
        issue(1'b1, 0);
        issue(1'b0, 0);
        issue(1'b0, 0);
        repeat (15) issue(1'($urandom_range(0, 1)), $urandom_range(0, 1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
